alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single `alu` instance between `NUM_REQ` independent requesters, e.g. the integer pipeline and the address-generation path. Each cycle it grants at most one requester round-robin, drives that request's operands and opcode into the ALU, and registers the result into a per-requester response slot. Each slot has its own valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32: operand and result width, passed to `alu`.
- `NUM_REQ`, 2: number of requesters (2..8).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ReqValid` in `NUM_REQ`: per-requester request valid.
- `ReqReady` out `NUM_REQ`: per-requester request accepted this cycle (one-hot or zero).
- `ReqOp` in `NUM_REQ`x4: `control_operation` per requester.
- `ReqA`, `ReqB` in `NUM_REQ`x`DATA_WIDTH`: operands per requester.
- `RspValid` out `NUM_REQ`: response slot holds a result.
- `RspReady` in `NUM_REQ`: consumer takes the response.
- `RspResult` out `NUM_REQ`x`DATA_WIDTH`: registered ALU result.
- `RspZero`, `RspNeg` out `NUM_REQ`: registered ZeroFlag / NegativeFlag.

## Operation
- Eligibility: requester i is eligible when `ReqValid[i]` is high and its slot is free, i.e. `!RspValid[i] || RspReady[i]`. A slot drained in the same cycle counts as free.
- Arbitration: a round-robin pointer `Ptr` (0..`NUM_REQ`-1) marks the highest-priority index.
  - Search order is `Ptr`, `Ptr+1`, … modulo `NUM_REQ`. The first eligible index is granted.
  - `ReqReady` is the one-hot grant. It is combinational from `ReqValid`, `RspValid`, `RspReady` and `Ptr`.
  - On a grant to g, `Ptr` becomes (g+1) mod `NUM_REQ`, wrapping from `NUM_REQ`-1 to 0. With no grant, `Ptr` holds.
- Datapath: the granted requester's `ReqOp`, `ReqA` and `ReqB` are muxed into `alu`.
  - With no grant, the mux drives op ADD with zero operands. Nothing is captured.
- Capture: on a grant to g, slot g loads the ALU result and flags, and `RspValid[g]` goes to 1.
- Drain: `RspValid[i]` && `RspReady[i]` with no new grant to i clears `RspValid[i]`.
  - Simultaneous drain and grant to the same i: slot i is overwritten and `RspValid[i]` stays 1. Back-to-back throughput is one result per cycle.
- A full slot with `RspReady` low blocks only its own requester. Other requesters continue to be granted.
- Unimplemented opcodes (0101..1111) are forwarded unchanged. The ALU returns result 0, so the slot holds Zero=1, Neg=0.
- Fairness: a continuously eligible requester is granted within `NUM_REQ` cycles.
- Consumer stability rule: `RspResult`, `RspZero` and `RspNeg` for slot i are stable while `RspValid[i]` is high and `RspReady[i]` is low.

## Timing
- Reset (async assert, sync deassert handled externally) sets:
  - `Ptr` = 0
  - `RspValid` = 0
  - `RspResult` = 0
  - `RspZero` = 0
  - `RspNeg` = 0
- `ReqReady` = 0 during reset.
- Reset mid-operation discards all pending responses. No response is produced for a request granted in the cycle reset asserts.
- Latency: a grant in cycle n makes `RspValid` high in cycle n+1.
- Combinational path: `RspReady` → `ReqReady`. Requesters must not derive `ReqValid` from `ReqReady`.
- `ReqValid` may drop without a grant. Request fields are sampled only in the grant cycle.

## Structure
- Shared package `alu_pkg`:
  - the `control_operation` enum, with values ADD 0000 through SLTU 1001;
  - `NUM_REQ_MAX` = 8.
- `alu` imports `alu_pkg` instead of declaring the enum locally.
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs `clk`, `rst_n`, `Req[N]`;
  - output `Grant[N]`, one-hot;
  - holds `Ptr`.
- The top level holds the operand mux, the `alu` instance and the response slots.

## Test plan
- Single request: `NUM_REQ`=2, requester 0 sends ADD 5+7 with `RspReady`=1.
  - `ReqReady[0]`=1 in cycle 0.
  - Cycle 1: `RspValid[0]`=1, result 12, Zero=0, Neg=0.
- Contention: both requesters valid every cycle with `RspReady` all 1, starting from `Ptr`=0.
  - Grants alternate 0,1,0,1.
  - Req1 SUB 3-5 returns 0xFFFFFFFE with Neg=1.
- Backpressure: requester 1 with `RspReady[1]`=0 after its first result.
  - The second request from 1 stalls (`ReqReady[1]`=0).
  - Requester 0 is granted every cycle meanwhile.
  - Releasing `RspReady[1]` grants requester 1 in that same cycle.
- Zero and unimplemented opcode cases:
  - XOR 0xA5A5A5A5^0xA5A5A5A5 → result 0, Zero=1.
  - Op 0101 (SLL) → result 0, Zero=1.
- Pointer wrap, `NUM_REQ`=4:
  - Only requester 3 valid → grant 3, `Ptr` wraps to 0.
  - Then requesters 0 and 3 valid → grant 0.
- Reset mid-operation: assert `rst_n`=0 asynchronously while `RspValid`=2'b11.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enumeration and arbiter sizing limits.
package alu_pkg;

    localparam int unsigned OP_WIDTH    = 4;
    localparam int unsigned NUM_REQ_MAX = 8;

    typedef enum logic [OP_WIDTH-1:0] {
        ADD  = 4'b0000,
        SUB  = 4'b0001,
        AND  = 4'b0010,
        OR   = 4'b0011,
        XOR  = 4'b0100,
        SLL  = 4'b0101,
        SRL  = 4'b0110,
        SRA  = 4'b0111,
        SLT  = 4'b1000,
        SLTU = 4'b1001
    } control_operation;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; opcodes without an implementation yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  control_operation        op,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [DATA_WIDTH-1:0]   result_c,
    output logic                    zero_flag_c,
    output logic                    negative_flag_c
);

    // Operation select; shifts and compares are reserved encodings here.
    always_comb begin
        result_c = '0;
        case (op)
            ADD:     result_c = a + b;
            SUB:     result_c = a - b;
            AND:     result_c = a & b;
            OR:      result_c = a | b;
            XOR:     result_c = a ^ b;
            default: result_c = '0;
        endcase
    end

    assign zero_flag_c     = (result_c == '0);
    assign negative_flag_c = result_c[DATA_WIDTH-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the priority pointer upward.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] Req,
    output logic [N-1:0] Grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW:0]   slot_c;
    logic [PW-1:0] gidx_c;
    logic          found_c;

    // Walk Ptr, Ptr+1, ... modulo N and take the first requester; no grant in reset.
    always_comb begin
        Grant   = '0;
        slot_c  = '0;
        gidx_c  = '0;
        found_c = 1'b0;
        for (int k = 0; k < N; k++) begin
            slot_c = {1'b0, ptr} + (PW+1)'(k);
            if (slot_c >= (PW+1)'(N)) begin
                slot_c = slot_c - (PW+1)'(N);
            end
            if (rst_n && !found_c && Req[slot_c[PW-1:0]]) begin
                found_c = 1'b1;
                gidx_c  = slot_c[PW-1:0];
            end
        end
        if (found_c) begin
            Grant[gidx_c] = 1'b1;
        end
    end

    // Priority moves just past the winner; held when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found_c) begin
            ptr <= (gidx_c == PW'(N-1)) ? '0 : gidx_c + PW'(1);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with per-requester registered response slots.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    ReqValid,
    output logic [NUM_REQ-1:0]                    ReqReady,
    input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]      ReqOp,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    ReqA,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    ReqB,
    output logic [NUM_REQ-1:0]                    RspValid,
    input  logic [NUM_REQ-1:0]                    RspReady,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    RspResult,
    output logic [NUM_REQ-1:0]                    RspZero,
    output logic [NUM_REQ-1:0]                    RspNeg
);

    logic [NUM_REQ-1:0]    eligible_c;
    logic [NUM_REQ-1:0]    grant_c;
    control_operation      alu_op_c;
    logic [DATA_WIDTH-1:0] alu_a_c;
    logic [DATA_WIDTH-1:0] alu_b_c;
    logic [DATA_WIDTH-1:0] alu_result_c;
    logic                  alu_zero_c;
    logic                  alu_neg_c;

    // A slot being drained this cycle can accept a new result.
    assign eligible_c = ReqValid & (~RspValid | RspReady);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .Req   (eligible_c),
        .Grant (grant_c)
    );

    assign ReqReady = grant_c;

    // Operand mux from the one-hot grant; idle value is ADD 0+0.
    always_comb begin
        alu_op_c = ADD;
        alu_a_c  = '0;
        alu_b_c  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                alu_op_c = control_operation'(ReqOp[i]);
                alu_a_c  = ReqA[i];
                alu_b_c  = ReqB[i];
            end
        end
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op              (alu_op_c),
        .a               (alu_a_c),
        .b               (alu_b_c),
        .result_c        (alu_result_c),
        .zero_flag_c     (alu_zero_c),
        .negative_flag_c (alu_neg_c)
    );

    // Response slots: a grant loads (overriding a same-cycle drain), otherwise a drain clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RspValid  <= '0;
            RspResult <= '0;
            RspZero   <= '0;
            RspNeg    <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_c[i]) begin
                    RspValid[i]  <= 1'b1;
                    RspResult[i] <= alu_result_c;
                    RspZero[i]   <= alu_zero_c;
                    RspNeg[i]    <= alu_neg_c;
                end else if (RspReady[i]) begin
                    RspValid[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_alu_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][3:0]    req_op;
    logic [N-1:0][DW-1:0] req_a;
    logic [N-1:0][DW-1:0] req_b;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready;
    logic [N-1:0][DW-1:0] rsp_result;
    logic [N-1:0]         rsp_zero;
    logic [N-1:0]         rsp_neg;

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ReqValid  (req_valid),
        .ReqReady  (req_ready),
        .ReqOp     (req_op),
        .ReqA      (req_a),
        .ReqB      (req_b),
        .RspValid  (rsp_valid),
        .RspReady  (rsp_ready),
        .RspResult (rsp_result),
        .RspZero   (rsp_zero),
        .RspNeg    (rsp_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: slot contents and the round-robin priority index.
    bit            m_valid [N];
    logic [DW-1:0] m_res   [N];
    bit            m_zero  [N];
    bit            m_neg   [N];
    int            m_ptr;
    logic [N-1:0]  last_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_res[i]   = '0;
            m_zero[i]  = 1'b0;
            m_neg[i]   = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        req_op[i] = op;
        req_a[i]  = a;
        req_b[i]  = b;
    endtask

    // One cycle: compare outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        int            g;
        int            idx;
        logic [N-1:0]  eg;
        logic [N-1:0]  ev;
        logic [DW-1:0] r;
        @(negedge clk);
        g  = -1;
        eg = '0;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (req_valid[idx] && (!m_valid[idx] || rsp_ready[idx])) begin
                    g = idx;
                    break;
                end
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        for (int i = 0; i < N; i++) ev[i] = m_valid[i];
        last_ready = req_ready;
        check("req_ready", 64'(req_ready), 64'(eg));
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        for (int i = 0; i < N; i++) begin
            check($sformatf("slot%0d", i), {30'b0, rsp_zero[i], rsp_neg[i], rsp_result[i]},
                  {30'b0, m_zero[i], m_neg[i], m_res[i]});
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (g == i) begin
                    r          = ref_alu(req_op[i], req_a[i], req_b[i]);
                    m_res[i]   = r;
                    m_zero[i]  = (r == '0);
                    m_neg[i]   = r[DW-1];
                    m_valid[i] = 1'b1;
                end else if (m_valid[i] && rsp_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (g >= 0) m_ptr = (g + 1) % N;
        end
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = '1;
        repeat (n) step();
    endtask

    logic [N-1:0] prev;

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        model_reset();

        // Reset state, with requests pending
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_result", 64'(rsp_result == '0), 64'(1));
        step();
        rst_n = 1'b1;

        // Single request: ADD 5+7
        req_valid = 4'b0001;
        set_req(0, 4'd0, 32'd5, 32'd7);
        step();
        check("single_ready", 64'(last_ready), 64'(4'b0001));
        check("single_rsp", {31'b0, rsp_valid[0], rsp_zero[0], rsp_neg[0], rsp_result[0]},
              {31'b0, 1'b1, 1'b0, 1'b0, 32'd12});

        // Contention between 0 and 1: grants alternate
        req_valid = 4'b0011;
        set_req(0, 4'd0, 32'd1, 32'd2);
        set_req(1, 4'd1, 32'd3, 32'd5);
        step();
        prev = last_ready;
        for (int c = 0; c < 4; c++) begin
            step();
            check("alternate", 64'(last_ready ^ prev), 64'(4'b0011));
            prev = last_ready;
        end
        check("sub_neg", {31'b0, rsp_neg[1], rsp_result[1]}, {31'b0, 1'b1, 32'hFFFF_FFFE});

        // Backpressure on slot 1
        idle(2);
        req_valid = 4'b0011;
        rsp_ready = 4'b1101;
        set_req(1, 4'd3, 32'h0F0F_0000, 32'h0000_00F0);
        for (int c = 0; c < 5; c++) begin
            step();
            if (c >= 2) check("bp_stall", 64'(last_ready), 64'(4'b0001));
        end
        rsp_ready = 4'b1111;
        step();
        check("bp_release", 64'(last_ready), 64'(4'b0010));

        // Zero result from XOR and from an unimplemented opcode
        idle(2);
        req_valid = 4'b0001;
        set_req(0, 4'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        step();
        check("xor_zero", {31'b0, rsp_zero[0], rsp_result[0]}, {31'b0, 1'b1, 32'd0});
        req_valid = 4'b0010;
        set_req(1, 4'd5, 32'd1, 32'd3);
        step();
        check("sll_zero", {30'b0, rsp_zero[1], rsp_neg[1], rsp_result[1]},
              {30'b0, 1'b1, 1'b0, 32'd0});

        // Pointer wrap from the last requester back to 0
        idle(2);
        req_valid = 4'b1000;
        set_req(3, 4'd0, 32'd9, 32'd9);
        step();
        check("wrap_grant3", 64'(last_ready), 64'(4'b1000));
        req_valid = 4'b1001;
        step();
        check("wrap_grant0", 64'(last_ready), 64'(4'b0001));

        // Asynchronous reset with two full slots
        idle(2);
        req_valid = 4'b0011;
        rsp_ready = 4'b0000;
        set_req(0, 4'd0, 32'd100, 32'd1);
        set_req(1, 4'd1, 32'd0, 32'd1);
        step();
        step();
        check("pre_rst_valid", 64'(rsp_valid), 64'(4'b0011));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(rsp_valid), 64'(0));
        check("async_result", 64'(rsp_result == '0), 64'(1));
        check("async_flags", 64'({rsp_zero, rsp_neg}), 64'(0));
        check("async_ready", 64'(req_ready), 64'(0));
        model_reset();
        step();
        rst_n     = 1'b1;
        rsp_ready = 4'b1111;
        step();
        check("post_rst_grant", 64'(last_ready), 64'(4'b0001));

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
                req_op[i]    = 4'($urandom_range(0, 15));
                req_a[i]     = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
                req_b[i]     = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
            end
            step();
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
